// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: depth derivation and
// legality checks on the almost-full/almost-empty thresholds.
package fifo_pkg;

  localparam int AFULL_MIN  = 1;
  localparam int AEMPTY_MIN = 0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit levels_ok(input int afull_lvl, input int aempty_lvl, input int depth);
    return (afull_lvl >= AFULL_MIN) && (afull_lvl <= depth) &&
           (aempty_lvl >= AEMPTY_MIN) && (aempty_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM with one write port and one registered read port.
// The storage array and read register are deliberately left without reset.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds the last dequeued word otherwise
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with bypass, synchronous flush, registered count/flags,
// programmable almost thresholds and sticky overflow/underflow.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int AFULL_LVL  = 28,
  parameter int AEMPTY_LVL = 2
) (
  input  logic              clk,
  input  logic              resetf,
  input  logic              fifo_cleaning,
  input  logic              clr_errors,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en_queue,
  input  logic              de_queue,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  if (!levels_ok(AFULL_LVL, AEMPTY_LVL, DEPTH)) begin : g_bad_levels
    $error("param_fifo: AFULL_LVL/AEMPTY_LVL outside legal range");
  end

  logic [CNT_W-1:0]  head;
  logic [CNT_W-1:0]  tail;
  logic [CNT_W-1:0]  count_next;
  logic              bypass;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_evt;
  logic              udf_evt;
  logic              use_ram;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] ram_rdata;

  // Bypass only exists while empty, so it never overlaps an accepted read.
  always_comb begin
    bypass     = empty & en_queue & de_queue;
    wr_acc     = en_queue & ~full & ~bypass & ~fifo_cleaning;
    rd_acc     = de_queue & ~empty & ~fifo_cleaning;
    ovf_evt    = en_queue & full;
    udf_evt    = de_queue & empty & ~en_queue;
    count_next = fill_count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (tail[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (head[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      head         <= '0;
      tail         <= '0;
      fill_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (fifo_cleaning) begin
      head         <= '0;
      tail         <= '0;
      fill_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      head         <= head + CNT_W'(rd_acc);
      tail         <= tail + CNT_W'(wr_acc);
      fill_count   <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);
    end
  end

  // The output word comes either from the RAM read register or from the
  // bypass/hold register; use_ram remembers which one was written last.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      use_ram    <= 1'b0;
      hold_q     <= '0;
      data_valid <= 1'b0;
    end else if (fifo_cleaning) begin
      use_ram    <= 1'b0;
      hold_q     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc | bypass;
      if (bypass) begin
        hold_q  <= data_in;
        use_ram <= 1'b0;
      end else if (rd_acc) begin
        use_ram <= 1'b1;
      end
    end
  end

  assign data_out = use_ram ? ram_rdata : hold_q;

  // A new error event in the same cycle as clr_errors keeps the flag set.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo_cleaning) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_errors) | ovf_evt;
      underflow <= (underflow & ~clr_errors) | udf_evt;
    end
  end

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!resetf)
    fill_count == CNT_W'(tail - head));

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios with literal
// expectations plus randomized traffic checked against a queue model.
module tb_param_fifo;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 32;
  localparam int AFULL_LVL  = 28;
  localparam int AEMPTY_LVL = 2;

  logic              clk = 1'b0;
  logic              resetf;
  logic              fifo_cleaning = 1'b0;
  logic              clr_errors = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              en_queue = 1'b0;
  logic              de_queue = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fill_count;
  logic              overflow;
  logic              underflow;

  int n_checks = 0;
  int n_fails  = 0;
  bit checking_on = 1'b0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] m_out   = '0;
  bit                m_valid = 1'b0;
  bit                m_ovf   = 1'b0;
  bit                m_udf   = 1'b0;

  param_fifo #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) dut (
    .clk           (clk),
    .resetf        (resetf),
    .fifo_cleaning (fifo_cleaning),
    .clr_errors    (clr_errors),
    .data_in       (data_in),
    .en_queue      (en_queue),
    .de_queue      (de_queue),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .fill_count    (fill_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return just after it.
  task automatic applyStimulus(input bit en, input bit de, input logic [DATA_W-1:0] din,
                               input bit flush, input bit clr);
    en_queue      = en;
    de_queue      = de;
    data_in       = din;
    fifo_cleaning = flush;
    clr_errors    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_fill_count"}, 32'(fill_count), 32'd0);
    checkBit({tag, "_full"}, full, 1'b0);
    checkBit({tag, "_empty"}, empty, 1'b1);
    checkBit({tag, "_almost_full"}, almost_full, 1'b0);
    checkBit({tag, "_almost_empty"}, almost_empty, 1'b1);
    checkOutput({tag, "_data_out"}, 32'(data_out), 32'd0);
    checkBit({tag, "_data_valid"}, data_valid, 1'b0);
    checkBit({tag, "_overflow"}, overflow, 1'b0);
    checkBit({tag, "_underflow"}, underflow, 1'b0);
  endtask

  // Queue model: a FIFO of words plus the last delivered word and sticky errors.
  always @(posedge clk) begin : model
    bit was_full;
    bit was_empty;
    bit wr_ok;
    if (resetf) begin
      if (fifo_cleaning) begin
        model_q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
      end else begin
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        wr_ok     = en_queue && !was_full;
        m_valid   = 1'b0;
        if (was_empty && en_queue && de_queue) begin
          m_out   = data_in;
          m_valid = 1'b1;
        end else begin
          if (de_queue && !was_empty) begin
            m_out   = model_q.pop_front();
            m_valid = 1'b1;
          end
          if (wr_ok) model_q.push_back(data_in);
        end
        m_ovf = (m_ovf && !clr_errors) || (en_queue && was_full);
        m_udf = (m_udf && !clr_errors) || (de_queue && was_empty && !en_queue);
      end
    end
  end

  always @(negedge resetf) begin
    model_q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  end

  always @(negedge clk) begin : compare
    int sz;
    if (resetf && checking_on) begin
      sz = model_q.size();
      checkBit("data_valid", data_valid, m_valid);
      checkOutput("data_out", 32'(data_out), 32'(m_out));
      checkOutput("fill_count", 32'(fill_count), 32'(sz));
      checkBit("full", full, sz == DEPTH);
      checkBit("empty", empty, sz == 0);
      checkBit("almost_full", almost_full, sz >= AFULL_LVL);
      checkBit("almost_empty", almost_empty, sz <= AEMPTY_LVL);
      checkBit("overflow", overflow, m_ovf);
      checkBit("underflow", underflow, m_udf);
    end
  end

  initial begin
    resetf = 1'b1;
    #2 resetf = 1'b0;
    #1 checkResetValues("reset");
    repeat (2) @(posedge clk);
    #2 resetf = 1'b1;
    checking_on = 1'b1;

    // Fill to full
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
      if (i == 27) checkBit("almost_full_at_27", almost_full, 1'b0);
      if (i == 28) checkBit("almost_full_at_28", almost_full, 1'b1);
    end
    checkOutput("fill_count_at_32", 32'(fill_count), 32'd32);
    checkBit("full_at_32", full, 1'b1);

    // Overflow is sticky and the dropped word never surfaces
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    checkBit("overflow_set", overflow, 1'b1);
    checkOutput("fill_count_after_ovf", 32'(fill_count), 32'd32);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkBit("overflow_sticky", overflow, 1'b1);

    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      checkBit("drain_valid", data_valid, 1'b1);
      checkOutput("drain_data", 32'(data_out), 32'(i));
      if (i == 29) checkBit("almost_empty_at_3", almost_empty, 1'b0);
      if (i == 30) checkBit("almost_empty_at_2", almost_empty, 1'b1);
    end
    checkBit("empty_after_drain", empty, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkBit("idle_valid_low", data_valid, 1'b0);
    checkOutput("idle_data_hold", 32'(data_out), 32'h20);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkBit("overflow_cleared", overflow, 1'b0);

    // Bypass on empty, then underflow
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    checkOutput("bypass_data", 32'(data_out), 32'h1234);
    checkBit("bypass_valid", data_valid, 1'b1);
    checkOutput("bypass_fill_count", 32'(fill_count), 32'd0);
    checkBit("bypass_no_underflow", underflow, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    checkBit("underflow_valid_low", data_valid, 1'b0);
    checkBit("underflow_set", underflow, 1'b1);
    checkOutput("underflow_data_hold", 32'(data_out), 32'h1234);

    // Steady count of 5 with simultaneous traffic across pointer wrap
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 16'(16'h0100 + k), 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h0200 + j), 1'b0, 1'b0);
      checkOutput("wrap_fill_count", 32'(fill_count), 32'd5);
      checkBit("wrap_valid", data_valid, 1'b1);
      checkOutput("wrap_data", 32'(data_out), (j < 5) ? 32'(16'h0100 + j) : 32'(16'h0200 + j - 5));
    end

    // Flush with 10 stored words and a pending underflow
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 16'(16'h0300 + k), 1'b0, 1'b0);
    checkOutput("pre_flush_count", 32'(fill_count), 32'd10);
    applyStimulus(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    checkResetValues("flush");
    applyStimulus(1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    checkOutput("post_flush_data", 32'(data_out), 32'hCAFE);
    checkBit("post_flush_valid", data_valid, 1'b1);

    // Randomized traffic in phases biased toward filling, draining or balance
    for (int c = 0; c < 3000; c++) begin
      int en_pct;
      int de_pct;
      case ((c / 150) % 3)
        0:       begin en_pct = 85; de_pct = 25; end
        1:       begin en_pct = 25; de_pct = 85; end
        default: begin en_pct = 55; de_pct = 55; end
      endcase
      applyStimulus($urandom_range(0, 99) < en_pct, $urandom_range(0, 99) < de_pct,
                    16'($urandom), $urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in the middle of a burst
    applyStimulus(1'b1, 1'b0, 16'h0A0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0B0B, 1'b0, 1'b0);
    en_queue = 1'b1;
    de_queue = 1'b1;
    data_in  = 16'h0C0C;
    #2 resetf = 1'b0;
    #1 checkResetValues("async_reset");
    @(posedge clk);
    #1 resetf = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0);
    checkOutput("after_reset_count", 32'(fill_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    checkOutput("after_reset_data", 32'(data_out), 32'h5A5A);
    checkBit("after_reset_valid", data_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    checking_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
